// File: rtl/switch_debounce.sv
// switch_debounce: two-flop synchroniser plus per-bit stability counters for slide switches,
// with registered rise/fall/any-change pulses aligned to the debounced level.
module switch_debounce #(
    parameter int WIDTH           = 11,
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] sw_raw,
    output logic [WIDTH-1:0] sw_stable,
    output logic [WIDTH-1:0] sw_rise,
    output logic [WIDTH-1:0] sw_fall,
    output logic             sw_changed
);
    localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic [WIDTH-1:0]         sync1_q, sync2_q;
    logic [WIDTH-1:0]         stable_q, stable_d;
    logic [WIDTH-1:0]         rise_q, rise_d, fall_q, fall_d;
    logic                     changed_q, changed_d;
    logic [WIDTH-1:0]         diff, hit;
    logic [WIDTH-1:0][CW-1:0] cnt_q, cnt_d;

    assign diff = sync2_q ^ stable_q;

    // Any agreeing sample clears the run, so only an unbroken disagreement reaches LAST
    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        assign hit[i]   = diff[i] && (cnt_q[i] == LAST);
        assign cnt_d[i] = (diff[i] && !hit[i]) ? cnt_q[i] + CW'(1) : '0;
    end

    assign stable_d  = stable_q ^ hit;
    assign rise_d    = hit & sync2_q;
    assign fall_d    = hit & ~sync2_q;
    assign changed_d = |{rise_d, fall_d};

    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_q   <= '0;
            sync2_q   <= '0;
            cnt_q     <= '0;
            stable_q  <= '0;
            rise_q    <= '0;
            fall_q    <= '0;
            changed_q <= 1'b0;
        end else begin
            sync1_q   <= sw_raw;
            sync2_q   <= sync1_q;
            cnt_q     <= cnt_d;
            stable_q  <= stable_d;
            rise_q    <= rise_d;
            fall_q    <= fall_d;
            changed_q <= changed_d;
        end
    end

    assign sw_stable  = stable_q;
    assign sw_rise    = rise_q;
    assign sw_fall    = fall_q;
    assign sw_changed = changed_q;
endmodule

// File: tb/tb_switch_debounce.sv
// tb_switch_debounce: directed scenarios plus random switch bouncing, checked against a
// sliding-window model (accept once the last D synchronised samples all disagree).
module tb_switch_debounce;
    localparam int W = 11;
    localparam int D = 4;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic [W-1:0] sw_raw = '0;
    logic [W-1:0] sw_stable, sw_rise, sw_fall;
    logic         sw_changed;
    int           checks = 0;
    int           fails = 0;

    switch_debounce #(.WIDTH(W), .DEBOUNCE_CYCLES(D)) dut (
        .clk(clk), .reset(reset), .sw_raw(sw_raw), .sw_stable(sw_stable),
        .sw_rise(sw_rise), .sw_fall(sw_fall), .sw_changed(sw_changed)
    );

    always #5 clk = ~clk;

    // Reference model: raw levels reach the debouncer two edges late; a bit flips when
    // its last D delivered samples all differ from the accepted level.
    logic [W-1:0] m_stable = '0, m_rise = '0, m_fall = '0;
    logic         m_chg = 1'b0;
    logic [W-1:0] dly[$];
    logic [W-1:0] win[$];

    always @(posedge clk) begin
        if (reset) begin
            dly = '{W'(0), W'(0)};
            win.delete();
            m_stable = '0; m_rise = '0; m_fall = '0; m_chg = 1'b0;
        end else begin
            win.push_back(dly.pop_front());
            dly.push_back(sw_raw);
            if (win.size() > D) void'(win.pop_front());
            m_rise = '0;
            m_fall = '0;
            for (int i = 0; i < W; i++) begin
                bit all_diff;
                all_diff = (win.size() == D);
                foreach (win[j]) if (win[j][i] == m_stable[i]) all_diff = 1'b0;
                if (all_diff) begin
                    m_rise[i]   = !m_stable[i];
                    m_fall[i]   = m_stable[i];
                    m_stable[i] = !m_stable[i];
                end
            end
            m_chg = |{m_rise, m_fall};
        end
    end

    task automatic tick(input logic [W-1:0] raw, input logic rst);
        sw_raw = raw;
        reset  = rst;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset;
        for (int j = 0; j < 3; j++) begin
            tick(11'h7FF, 1'b1);
            checks++;
            if ({sw_stable, sw_rise, sw_fall, sw_changed} !== '0) begin
                fails++;
                $display("FAIL reset_hold: got %h/%h/%h/%b want all 0", sw_stable, sw_rise, sw_fall, sw_changed);
            end
        end
        for (int j = 0; j < 8; j++) begin
            tick(11'h7FF, 1'b0);
            checks++;
            if (sw_stable !== (j >= 5 ? 11'h7FF : 11'h000) || sw_rise !== (j == 5 ? 11'h7FF : 11'h000)
                || sw_changed !== (j == 5) || sw_fall !== '0) begin
                fails++;
                $display("FAIL reset_release edge %0d: got stable=%h rise=%h fall=%h chg=%b", j, sw_stable, sw_rise, sw_fall, sw_changed);
            end
            checks++;
            if ({sw_stable, sw_rise, sw_fall, sw_changed} !== {m_stable, m_rise, m_fall, m_chg}) begin
                fails++;
                $display("FAIL reset_model edge %0d: got %h/%h/%h/%b want %h/%h/%h/%b", j, sw_stable, sw_rise, sw_fall, sw_changed, m_stable, m_rise, m_fall, m_chg);
            end
        end
    endtask

    task automatic test_clean_edge;
        int rises = 0;
        tick('0, 1'b1);
        for (int j = 0; j < 3; j++) tick('0, 1'b0);
        for (int j = 0; j < 10; j++) begin
            tick(11'h008, 1'b0);
            rises += sw_rise[3];
            checks++;
            if (sw_stable !== (j >= 5 ? 11'h008 : 11'h000) || sw_rise !== (j == 5 ? 11'h008 : 11'h000) || sw_fall !== '0) begin
                fails++;
                $display("FAIL clean_edge edge %0d: got stable=%h rise=%h fall=%h", j, sw_stable, sw_rise, sw_fall);
            end
        end
        checks++;
        if (rises != 1) begin
            fails++;
            $display("FAIL clean_edge_pulses: got %0d rise pulses want 1", rises);
        end
    endtask

    task automatic test_glitch;
        for (int j = 0; j < 13; j++) begin
            tick(11'h008 | W'(j != 3), 1'b0);
            checks++;
            if (sw_stable !== (11'h008 | W'(j >= 9)) || sw_rise !== W'(j == 9) || sw_fall !== '0 || sw_changed !== (j == 9)) begin
                fails++;
                $display("FAIL glitch edge %0d: got stable=%h rise=%h fall=%h chg=%b", j, sw_stable, sw_rise, sw_fall, sw_changed);
            end
            checks++;
            if ({sw_stable, sw_rise, sw_fall, sw_changed} !== {m_stable, m_rise, m_fall, m_chg}) begin
                fails++;
                $display("FAIL glitch_model edge %0d: got %h/%h/%h/%b want %h/%h/%h/%b", j, sw_stable, sw_rise, sw_fall, sw_changed, m_stable, m_rise, m_fall, m_chg);
            end
        end
    endtask

    task automatic test_fall;
        tick(11'h001, 1'b1);
        for (int j = 0; j < 7; j++) tick(11'h001, 1'b0);
        checks++;
        if (sw_stable !== 11'h001) begin
            fails++;
            $display("FAIL fall_setup: got stable=%h want 001", sw_stable);
        end
        for (int j = 0; j < 9; j++) begin
            tick('0, 1'b0);
            checks++;
            if (sw_stable !== W'(j < 5) || sw_fall !== W'(j == 5) || sw_rise !== '0 || sw_changed !== (j == 5)) begin
                fails++;
                $display("FAIL fall edge %0d: got stable=%h rise=%h fall=%h chg=%b", j, sw_stable, sw_rise, sw_fall, sw_changed);
            end
        end
    endtask

    task automatic test_simultaneous;
        int pulses = 0;
        for (int j = 0; j < 7; j++) tick(11'h400, 1'b0);
        for (int j = 0; j < 9; j++) begin
            tick(11'h002, 1'b0);
            pulses += int'(sw_changed);
            checks++;
            if (sw_rise !== (j == 5 ? 11'h002 : 11'h000) || sw_fall !== (j == 5 ? 11'h400 : 11'h000)
                || sw_stable !== (j >= 5 ? 11'h002 : 11'h400)) begin
                fails++;
                $display("FAIL simultaneous edge %0d: got stable=%h rise=%h fall=%h", j, sw_stable, sw_rise, sw_fall);
            end
        end
        checks++;
        if (pulses != 1) begin
            fails++;
            $display("FAIL simultaneous_changed: got %0d changed pulses want 1", pulses);
        end
    endtask

    task automatic test_reset_mid_count;
        for (int j = 0; j < 4; j++) tick(11'h003, 1'b0);
        tick(11'h003, 1'b1);
        checks++;
        if ({sw_stable, sw_rise, sw_fall, sw_changed} !== '0) begin
            fails++;
            $display("FAIL mid_reset: got %h/%h/%h/%b want all 0", sw_stable, sw_rise, sw_fall, sw_changed);
        end
        for (int j = 0; j < 7; j++) begin
            tick(11'h003, 1'b0);
            checks++;
            if (sw_stable !== (j >= 5 ? 11'h003 : 11'h000) || sw_rise !== (j == 5 ? 11'h003 : 11'h000)) begin
                fails++;
                $display("FAIL mid_reset_release edge %0d: got stable=%h rise=%h", j, sw_stable, sw_rise);
            end
        end
    endtask

    task automatic test_random;
        logic [W-1:0] raw = '0;
        for (int n = 0; n < 3000; n++) begin
            for (int i = 0; i < W; i++) if ($urandom_range(0, 6) == 0) raw[i] = !raw[i];
            tick(raw, $urandom_range(0, 299) == 0);
            checks++;
            if ({sw_stable, sw_rise, sw_fall, sw_changed} !== {m_stable, m_rise, m_fall, m_chg}) begin
                fails++;
                $display("FAIL random cycle %0d: got %h/%h/%h/%b want %h/%h/%h/%b", n, sw_stable, sw_rise, sw_fall, sw_changed, m_stable, m_rise, m_fall, m_chg);
            end
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL timeout: bench did not finish in time");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset;
        test_clean_edge;
        test_glitch;
        test_fall;
        test_simultaneous;
        test_reset_mid_count;
        test_random;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", checks, fails);
        $finish;
    end
endmodule
